red_pitaya_sort_scheduler: RTL and testbench
============================================

// Module: red_pitaya_sort_scheduler
// PURPOSE
//  Time-ordered scheduler for the sort actuator. Sits between the FADS droplet evaluator and the sort trigger output.
//  Each request is queued with an absolute deadline (now + delay), so several droplets can be in flight inside the delay window.
//  At each deadline it drives a sort pulse of programmable duration.
//  Overlapping pulses merge into one continuous pulse by retriggering.
// PARAMETERS
//  AW   3   log2 of queue depth (DEPTH = 2**AW entries)
//  CW   32  width of timestamp, delay, duration and statistics counters
// PORTS
//  adc_clk_i       in   1     ADC clock, sole clock
//  adc_rstn_i      in   1     reset, asynchronous, active-low
//  req_i           in   1     sort request, one per high cycle
//  enable_i        in   1     1 = accept requests; 0 = ignore new requests, queued entries still fire
//  clear_i         in   1     synchronous flush of queue, FSM and counters
//  cfg_delay_i     in   CW    delay in cycles; bit CW-1 is ignored (forced 0)
//  cfg_duration_i  in   CW    pulse length in cycles, sampled at pulse start and at each retrigger
//  sort_trig_o     out  1     sort pulse (registered)
//  busy_o          out  1     FSM not IDLE or queue non-empty
//  pending_o       out  AW+1  number of queued entries
//  fired_cnt_o     out  CW    entries consumed (includes merged entries)
//  merged_cnt_o    out  CW    entries absorbed by retrigger
//  dropped_cnt_o   out  CW    requests lost because the queue was full
// BEHAVIOUR
//  Reset: all outputs, queue pointers, timestamp and counters are 0; FSM is IDLE.
//  Timestamp ts: free-running CW-bit counter, wraps modulo 2**CW.
//  Push: when req_i & enable_i, deadline = ts + cfg_delay_i (mod 2**CW) is written to the queue.
//    The entry is visible to the FSM on the next cycle.
//  Full: a push while full is refused and dropped_cnt increments,
//    unless a pop happens in the same cycle; the push is then accepted.
//  Reached test (wrap-safe): head is reached iff MSB of (ts - deadline) is 0.
//    Late entries (deadline already passed) fire immediately.
//  Latency: req_i high in cycle T -> first sort_trig_o high in cycle T + max(D,1) + 1, queue idle.
//  FSM states:
//   IDLE: queue empty. -> WAIT on non-empty.
//   WAIT: head not reached -> stay.
//     Head reached and duration > 0 -> pop, load counter, go to FIRE; sort_trig_o = 1 next cycle.
//     Head reached and duration == 0 -> pop, fired_cnt++, no pulse; go to WAIT/IDLE.
//   FIRE: sort_trig_o = 1 and counter decrements.
//     Head reached in any FIRE cycle -> pop, reload cfg_duration_i, fired_cnt++, merged_cnt++; pulse stays high (no gap).
//     Counter expires with no retrigger -> sort_trig_o = 0, go to GAP.
//   GAP: minimum low time (see CONFIGURATION), then -> WAIT/IDLE.
//  Pulse length: exactly cfg_duration_i cycles counted from the last start or retrigger.
//  fired_cnt increments on every pop.
//  Counters saturate at all-ones and never wrap.
//  clear_i (priority over push/pop): next cycle queue empty, FSM IDLE, sort_trig_o = 0, all counters 0.
//    A req_i in the same cycle is discarded.
//  ts keeps running through clear_i.
//  Async reset mid-pulse: sort_trig_o drops immediately on reset assertion.
// CONFIGURATION
//  SORT_SCHED_HOLDOFF_EN defined:
//    Adds input cfg_holdoff_i [CW].
//    GAP lasts max(1, cfg_holdoff_i) cycles; entries reached during GAP wait and fire at GAP exit.
//    Retrigger inside FIRE is unaffected.
//  Not defined:
//    No port. GAP lasts exactly 1 cycle: a reached head after a pulse gives exactly 1 low cycle between pulses.
// TESTING
//  1. D=10, duration=5, one req at ts=100 -> trig high ts 111..115, fired=1, pending back to 0.
//  2. D=20, duration=8, reqs at ts 0 and 4 -> trig high ts 21..32 continuous, fired=2, merged=1.
//  3. DEPTH=8, nine reqs back-to-back, D=1000 -> pending=8, dropped=1, exactly 8 entries fire.
//  4. ts preloaded near 2**CW-5, D=10 -> pulse fires after wrap with latency 11; no early fire.
//  5. clear_i mid-pulse with 3 queued -> next cycle trig=0, pending=0, counters=0, req in the same cycle ignored.
//  6. HOLDOFF_EN, holdoff=6, duration=3, second deadline during GAP -> exactly 6 low cycles, then 3 high.

Source files
------------

// File: rtl/red_pitaya_sort_scheduler.sv
// Time-ordered sort scheduler: queues absolute deadlines (ts + delay) and
// drives a sort pulse of programmable length when each deadline is reached.
// A deadline reached while the pulse is high retriggers it (merge, no gap).
// Optional feature macro: SORT_SCHED_HOLDOFF_EN adds cfg_holdoff_i, which sets
// the minimum low time between pulses; without it the gap is one cycle.
//
// state | meaning
// IDLE  | queue empty, output low
// WAIT  | head queued, deadline not reached yet
// FIRE  | sort pulse high, duration counter running
// GAP   | minimum low time after a pulse
module red_pitaya_sort_scheduler #(
  parameter int AW = 3,
  parameter int CW = 32
) (
  input  logic          adc_clk_i,
  input  logic          adc_rstn_i,
  input  logic          req_i,
  input  logic          enable_i,
  input  logic          clear_i,
  input  logic [CW-1:0] cfg_delay_i,
  input  logic [CW-1:0] cfg_duration_i,
`ifdef SORT_SCHED_HOLDOFF_EN
  input  logic [CW-1:0] cfg_holdoff_i,
`endif
  output logic          sort_trig_o,
  output logic          busy_o,
  output logic [AW:0]   pending_o,
  output logic [CW-1:0] fired_cnt_o,
  output logic [CW-1:0] merged_cnt_o,
  output logic [CW-1:0] dropped_cnt_o
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FIRE, S_GAP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          trig_q, trig_d;
  logic [CW-1:0] ts_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [CW-1:0] mem_q [DEPTH];
  logic [CW-1:0] fired_q, merged_q, dropped_q;

  logic [CW-1:0]        delay_eff, gap_len, head;
  logic signed [CW-1:0] lag_s;
  logic                 reached, push_req, push, drop, pop, merge, idle_next, can_dispatch;
  logic                 unused_delay_msb;

  // The delay MSB is forced to 0 so a deadline is never more than half the
  // timestamp range ahead, which keeps the sign-based reached test unambiguous.
  assign unused_delay_msb = cfg_delay_i[CW-1];
  assign delay_eff        = {1'b0, cfg_delay_i[CW-2:0]};

`ifdef SORT_SCHED_HOLDOFF_EN
  assign gap_len = (cfg_holdoff_i == '0) ? CW'(1) : cfg_holdoff_i;
`else
  assign gap_len = CW'(1);
`endif

  // Wrap-safe deadline test on the queue head; late entries count as reached.
  assign head    = mem_q[rd_ptr_q];
  assign lag_s   = $signed(ts_q - head);
  assign reached = (count_q != '0) && (lag_s >= $signed(CW'(0)));

  // Queue admission: a full queue still accepts a push when a pop frees a slot.
  always_comb begin
    push_req = req_i & enable_i;
    push     = push_req && ((count_q != (AW+1)'(DEPTH)) || pop);
    drop     = push_req && (count_q == (AW+1)'(DEPTH)) && !pop;
  end

  // Next-state, pop and duration/gap counter control.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pop          = 1'b0;
    merge        = 1'b0;
    idle_next    = 1'b0;
    can_dispatch = (state_q == S_IDLE) || (state_q == S_WAIT) ||
                   ((state_q == S_GAP) && (cnt_q <= CW'(1)));
    if (state_q == S_FIRE) begin
      if (reached) begin
        pop   = 1'b1;
        merge = 1'b1;
        if (cfg_duration_i != '0) begin
          cnt_d = cfg_duration_i;
        end else begin
          state_d = S_GAP;
          cnt_d   = gap_len;
        end
      end else if (cnt_q <= CW'(1)) begin
        state_d = S_GAP;
        cnt_d   = gap_len;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else if (can_dispatch) begin
      pop       = reached;
      idle_next = reached ? ((count_q == (AW+1)'(1)) && !push_req) : (count_q == '0);
      if (reached && (cfg_duration_i != '0)) begin
        state_d = S_FIRE;
        cnt_d   = cfg_duration_i;
      end else begin
        state_d = idle_next ? S_IDLE : S_WAIT;
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
    trig_d = (state_d == S_FIRE);
  end

  // Queue storage; contents need no reset because occupancy is tracked by count_q.
  always_ff @(posedge adc_clk_i) begin
    if (push && !clear_i) mem_q[wr_ptr_q] <= ts_q + delay_eff;
  end

  // Timestamp, queue pointers, FSM, pulse register and saturating statistics.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      ts_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      trig_q    <= 1'b0;
      fired_q   <= '0;
      merged_q  <= '0;
      dropped_q <= '0;
    end else begin
      ts_q <= ts_q + CW'(1);
      if (clear_i) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        count_q   <= '0;
        state_q   <= S_IDLE;
        cnt_q     <= '0;
        trig_q    <= 1'b0;
        fired_q   <= '0;
        merged_q  <= '0;
        dropped_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
        state_q <= state_d;
        cnt_q   <= cnt_d;
        trig_q  <= trig_d;
        if (pop   && (fired_q   != '1)) fired_q   <= fired_q   + CW'(1);
        if (merge && (merged_q  != '1)) merged_q  <= merged_q  + CW'(1);
        if (drop  && (dropped_q != '1)) dropped_q <= dropped_q + CW'(1);
      end
    end
  end

  assign sort_trig_o   = trig_q;
  assign busy_o        = (state_q != S_IDLE) || (count_q != '0);
  assign pending_o     = count_q;
  assign fired_cnt_o   = fired_q;
  assign merged_cnt_o  = merged_q;
  assign dropped_cnt_o = dropped_q;

endmodule

// File: tb/tb_red_pitaya_sort_scheduler.sv
// Scoreboard bench for red_pitaya_sort_scheduler. The reference model keeps
// deadlines as absolute (non-wrapping) cycle numbers and the pulse as an
// interval [s_m, e_m]; the DUT is built with CW=12 so timestamp wrap occurs.
module tb_red_pitaya_sort_scheduler;
  localparam int AW = 3;
  localparam int CW = 12;
  localparam int DEPTH = 8;
  localparam longint CMAX = 4095;
`ifdef SORT_SCHED_HOLDOFF_EN
  localparam int G = 6;
  logic [CW-1:0] holdoff = 12'd6;
`else
  localparam int G = 1;
`endif

  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, en = 1'b0, clr = 1'b0;
  logic [CW-1:0] delay = '0, dur = '0;
  logic          sort_trig, busy;
  logic [AW:0]   pending;
  logic [CW-1:0] fired_cnt, merged_cnt, dropped_cnt;

  red_pitaya_sort_scheduler #(.AW(AW), .CW(CW)) dut (
    .adc_clk_i      (clk),
    .adc_rstn_i     (rst_n),
    .req_i          (req),
    .enable_i       (en),
    .clear_i        (clr),
    .cfg_delay_i    (delay),
    .cfg_duration_i (dur),
`ifdef SORT_SCHED_HOLDOFF_EN
    .cfg_holdoff_i  (holdoff),
`endif
    .sort_trig_o    (sort_trig),
    .busy_o         (busy),
    .pending_o      (pending),
    .fired_cnt_o    (fired_cnt),
    .merged_cnt_o   (merged_cnt),
    .dropped_cnt_o  (dropped_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint trig, busy, pending, fired, merged, dropped, mt;
  } exp_t;

  exp_t   exp_q[$];
  int     n_cmp = 0, n_err = 0;
  longint mt, s_m, e_m, fired_m, merged_m, dropped_m;
  longint dq[$];

  task automatic chk(input string name, input longint act, input longint expv, input longint when);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, when, act, expv);
    end
  endtask

  // Monitor: one expected record per cycle, compared away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        chk("trig",    longint'(sort_trig),   x.trig,    x.mt);
        chk("busy",    longint'(busy),        x.busy,    x.mt);
        chk("pending", longint'(pending),     x.pending, x.mt);
        chk("fired",   longint'(fired_cnt),   x.fired,   x.mt);
        chk("merged",  longint'(merged_cnt),  x.merged,  x.mt);
        chk("dropped", longint'(dropped_cnt), x.dropped, x.mt);
      end
    end
  end

  function automatic longint sat(input longint v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  function automatic void model_reset();
    mt = 0; dq.delete();
    fired_m = 0; merged_m = 0; dropped_m = 0;
    e_m = -G; s_m = 1;
  endfunction

  function automatic exp_t snap(input longint t);
    exp_t x;
    x.trig    = (t >= s_m && t <= e_m) ? 1 : 0;
    x.busy    = (dq.size() > 0 || (t >= s_m && t <= e_m + G)) ? 1 : 0;
    x.pending = dq.size();
    x.fired   = fired_m;
    x.merged  = merged_m;
    x.dropped = dropped_m;
    x.mt      = t;
    return x;
  endfunction

  // One cycle of the reference behaviour using this cycle's inputs.
  function automatic void model_step(input bit r, input bit e_in, input bit c);
    bit in_pulse, allowed;
    if (c) begin
      dq.delete();
      fired_m = 0; merged_m = 0; dropped_m = 0;
      e_m = mt + 1 - G; s_m = e_m + G + 1;
      return;
    end
    in_pulse = (mt >= s_m && mt <= e_m);
    allowed  = in_pulse || (mt >= e_m + G);
    if (dq.size() > 0 && allowed && dq[0] <= mt) begin
      void'(dq.pop_front());
      fired_m = sat(fired_m);
      if (in_pulse) begin
        merged_m = sat(merged_m);
        e_m = mt + longint'(dur);
      end else if (dur != 0) begin
        s_m = mt + 1;
        e_m = mt + longint'(dur);
      end
    end
    if (r && e_in) begin
      if (dq.size() < DEPTH) dq.push_back(mt + longint'(delay & 12'h7FF));
      else dropped_m = sat(dropped_m);
    end
  endfunction

  task automatic step(input bit r, input bit e_in, input bit c);
    req = r; en = e_in; clr = c;
    model_step(r, e_in, c);
    exp_q.push_back(snap(mt + 1));
    mt++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic release_rst();
    model_reset();
    exp_q.push_back(snap(0));
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    release_rst();
    idle(3);

    // Single request: delay 10, duration 5.
    delay = 12'd10; dur = 12'd5;
    step(1'b1, 1'b1, 1'b0);
    idle(25);

    // Two overlapping requests merge into one continuous pulse.
    delay = 12'd20; dur = 12'd8;
    step(1'b1, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 1'b0);
    idle(40);

    // Back-to-back pulses with a deadline landing in the gap.
    delay = 12'd5; dur = 12'd3;
    step(1'b1, 1'b1, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 1'b0);
    idle(30);

    // Nine requests into an eight-entry queue.
    delay = 12'd1000; dur = 12'd3;
    for (int k = 0; k < 9; k++) step(1'b1, 1'b1, 1'b0);
    idle(1050);

    // Duration zero consumes entries without a pulse; delay MSB ignored.
    delay = 12'h803; dur = 12'd0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    idle(12);

    // Clear mid-pulse with three entries queued and a request in the same cycle.
    delay = 12'd5; dur = 12'd10;
    step(1'b1, 1'b1, 1'b0);
    delay = 12'd30;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0);
    idle(4);
    step(1'b1, 1'b1, 1'b1);
    idle(50);

    // Request just before timestamp wrap.
    for (int k = 0; k < 5000 && (mt % 4096) != 4091; k++) step(1'b0, 1'b1, 1'b0);
    delay = 12'd10; dur = 12'd4;
    step(1'b1, 1'b1, 1'b0);
    idle(30);

    // Asynchronous reset in the middle of a pulse.
    delay = 12'd3; dur = 12'd10;
    step(1'b1, 1'b1, 1'b0);
    idle(6);
    chk("pre_reset_trig", longint'(sort_trig), snap(mt).trig, mt);
    exp_q.delete();
    req = 1'b0; en = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_reset_trig",    longint'(sort_trig), 0, mt);
    chk("async_reset_pending", longint'(pending),   0, mt);
    chk("async_reset_fired",   longint'(fired_cnt), 0, mt);
    @(posedge clk); @(posedge clk); #1;
    release_rst();
    idle(2);

    // Randomized traffic.
    delay = 12'd20; dur = 12'd4;
    for (int k = 0; k < 6000; k++) begin
      bit r, e_in, c;
      if ($urandom_range(0, 99) == 0)
        delay = 12'($urandom_range(0, 60)) | (($urandom_range(0, 3) == 0) ? 12'h800 : 12'h000);
      if ($urandom_range(0, 99) == 0)
        dur = 12'($urandom_range(0, 12));
      r    = ($urandom_range(0, 4) == 0);
      e_in = ($urandom_range(0, 9) != 0);
      c    = ($urandom_range(0, 699) == 0);
      step(r, e_in, c);
    end
    idle(200);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d unchecked records, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
